// File: rtl/mem_arbiter.sv
// Arbitrates one fixed-latency single-port SRAM between instruction fetch (IF) and load/store (MEM).
// Optional build macro MEM_ARB_RR_EN switches tie-breaking from fixed MEM priority to round robin.
module mem_arbiter #(
    parameter int BIT_NUMBER  = 32,
    parameter int WAIT_CYCLES = 3
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  if_req,
    input  logic [BIT_NUMBER-1:0] if_addr,
    output logic                  if_ready,
    output logic [BIT_NUMBER-1:0] if_rdata,
    output logic                  if_stall,
    input  logic                  mem_r_en,
    input  logic                  mem_w_en,
    input  logic [BIT_NUMBER-1:0] mem_addr,
    input  logic [BIT_NUMBER-1:0] mem_wdata,
    output logic                  mem_ready,
    output logic [BIT_NUMBER-1:0] mem_rdata,
    output logic                  mem_stall,
    output logic                  sram_cs,
    output logic                  sram_we,
    output logic [BIT_NUMBER-1:0] sram_addr,
    output logic [BIT_NUMBER-1:0] sram_wdata,
    input  logic [BIT_NUMBER-1:0] sram_rdata
);

    localparam logic [3:0] CNT_LOAD = 4'(WAIT_CYCLES - 1);
    localparam logic       REQ_IF   = 1'b0;
    localparam logic       REQ_MEM  = 1'b1;
`ifdef MEM_ARB_RR_EN
    localparam bit RR_ENABLE = 1'b1;
`else
    localparam bit RR_ENABLE = 1'b0;
`endif

    typedef enum logic [1:0] {
        S_IDLE   = 2'd0,
        S_ACCESS = 2'd1,
        S_DONE   = 2'd2
    } state_t;

    state_t                r_state;
    state_t                w_state_next;
    logic [3:0]            r_cnt;
    logic [3:0]            w_cnt_next;
    logic                  r_owner;
    logic                  r_last_grant;
    logic                  r_we;
    logic [BIT_NUMBER-1:0] r_addr;
    logic [BIT_NUMBER-1:0] r_wdata;

    logic w_mem_req;
    logic w_any_req;
    logic w_grant;
    logic w_winner;
    logic w_last_cycle;
    logic w_rr_pick;

    assign w_mem_req    = mem_r_en | mem_w_en;
    assign w_any_req    = w_mem_req | if_req;
    assign w_grant      = (r_state == S_IDLE) && w_any_req;
    assign w_last_cycle = (r_state == S_ACCESS) && (r_cnt == 4'd0);
    // Round robin hands a tie to whoever did not win last time.
    assign w_rr_pick    = ~r_last_grant;

    always_comb begin
        w_winner = REQ_IF;
        if (w_mem_req && if_req) begin
            w_winner = RR_ENABLE ? w_rr_pick : REQ_MEM;
        end else if (w_mem_req) begin
            w_winner = REQ_MEM;
        end
    end

    always_comb begin
        w_state_next = r_state;
        w_cnt_next   = r_cnt;
        case (r_state)
            S_IDLE: begin
                if (w_any_req) begin
                    w_state_next = S_ACCESS;
                    w_cnt_next   = CNT_LOAD;
                end
            end
            S_ACCESS: begin
                if (r_cnt != 4'd0) begin
                    w_cnt_next = r_cnt - 4'd1;
                end else begin
                    w_state_next = S_DONE;
                end
            end
            S_DONE:  w_state_next = S_IDLE;
            default: w_state_next = S_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= S_IDLE;
            r_cnt   <= 4'd0;
        end else begin
            r_state <= w_state_next;
            r_cnt   <= w_cnt_next;
        end
    end

    // Transaction parameters are frozen at grant so later input changes cannot disturb the SRAM.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_owner      <= REQ_IF;
            r_last_grant <= REQ_IF;
            r_we         <= 1'b0;
            r_addr       <= '0;
            r_wdata      <= '0;
        end else if (w_grant) begin
            r_owner      <= w_winner;
            r_last_grant <= w_winner;
            r_we         <= (w_winner == REQ_MEM) && mem_w_en;
            r_addr       <= (w_winner == REQ_MEM) ? mem_addr : if_addr;
            r_wdata      <= mem_wdata;
        end
    end

    // Index 0 serves IF, index 1 serves MEM.
    for (genvar gi = 0; gi < 2; gi++) begin : g_req
        logic                  r_ready;
        logic [BIT_NUMBER-1:0] r_rdata;
        logic                  w_mine;

        assign w_mine = w_last_cycle && (r_owner == 1'(gi));

        always_ff @(posedge clk) begin
            if (rst) begin
                r_ready <= 1'b0;
                r_rdata <= '0;
            end else begin
                r_ready <= w_mine;
                if (w_mine && !r_we) begin
                    r_rdata <= sram_rdata;
                end
            end
        end
    end

    assign sram_cs    = (r_state == S_ACCESS);
    assign sram_we    = sram_cs & r_we;
    assign sram_addr  = sram_cs ? r_addr : '0;
    assign sram_wdata = sram_we ? r_wdata : '0;

    assign if_ready   = g_req[0].r_ready;
    assign if_rdata   = g_req[0].r_rdata;
    assign mem_ready  = g_req[1].r_ready;
    assign mem_rdata  = g_req[1].r_rdata;
    assign if_stall   = if_req & ~if_ready;
    assign mem_stall  = w_mem_req & ~mem_ready;

endmodule

// File: tb/tb_mem_arbiter.sv
// Self-checking bench for mem_arbiter: directed table, reset-abort sequence and random
// transactions checked against a transaction-level reference model and an SRAM array.
module tb_mem_arbiter;
    localparam int BN = 32;
    localparam int W  = 3;
    localparam int MW = 2048;
`ifdef MEM_ARB_RR_EN
    localparam bit RR = 1'b1;
`else
    localparam bit RR = 1'b0;
`endif
    localparam int TIE_RR_DEP = RR ? 0 : 1;

    logic          clk = 1'b0;
    logic          rst;
    logic          if_req;
    logic [BN-1:0] if_addr;
    logic          if_ready;
    logic [BN-1:0] if_rdata;
    logic          if_stall;
    logic          mem_r_en;
    logic          mem_w_en;
    logic [BN-1:0] mem_addr;
    logic [BN-1:0] mem_wdata;
    logic          mem_ready;
    logic [BN-1:0] mem_rdata;
    logic          mem_stall;
    logic          sram_cs;
    logic          sram_we;
    logic [BN-1:0] sram_addr;
    logic [BN-1:0] sram_wdata;
    logic [BN-1:0] sram_rdata;

    mem_arbiter #(.BIT_NUMBER(BN), .WAIT_CYCLES(W)) dut (
        .clk(clk), .rst(rst),
        .if_req(if_req), .if_addr(if_addr), .if_ready(if_ready), .if_rdata(if_rdata), .if_stall(if_stall),
        .mem_r_en(mem_r_en), .mem_w_en(mem_w_en), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
        .mem_ready(mem_ready), .mem_rdata(mem_rdata), .mem_stall(mem_stall),
        .sram_cs(sram_cs), .sram_we(sram_we), .sram_addr(sram_addr), .sram_wdata(sram_wdata),
        .sram_rdata(sram_rdata)
    );

    always #5 clk = ~clk;

    // SRAM behaviour: data presented combinationally while selected, writes at each cs&we edge
    logic [BN-1:0] sram_mem [MW];
    assign sram_rdata = sram_cs ? sram_mem[sram_addr[10:0]] : '0;
    always @(posedge clk) begin
        if (sram_cs && sram_we) sram_mem[sram_addr[10:0]] <= sram_wdata;
    end

    // Reference model state
    logic [BN-1:0] ref_mem [MW];
    int            m_last;
    logic [BN-1:0] exp_if_rd;
    logic [BN-1:0] exp_mem_rd;

    int n_tests = 0;
    int n_fail  = 0;
    int n_txn   = 0;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // Caller is at a negedge with the DUT idle; returns which requester's ready fired first.
    task automatic do_txn(input logic ir, input logic [BN-1:0] ia, input logic mr, input logic mw,
                          input logic [BN-1:0] ma, input logic [BN-1:0] md, input bit scramble,
                          output int obs_first);
        int            n;
        int            who [2];
        logic          s_we [2];
        logic [BN-1:0] s_addr [2];
        logic [BN-1:0] s_wd [2];
        logic [BN-1:0] snap_if [2];
        logic [BN-1:0] snap_mem [2];
        logic [10:0]   idx;
        int            last_k;
        int            g;
        logic          e_cs, e_we, e_ir, e_mr;
        logic [BN-1:0] e_addr, e_wd;
        n = 0;
        obs_first = -1;
        if (ir && (mr || mw)) begin
            who[0] = RR ? ((m_last == 0) ? 1 : 0) : 1;
            who[1] = 1 - who[0];
            n = 2;
        end else if (mr || mw) begin
            who[0] = 1; n = 1;
        end else if (ir) begin
            who[0] = 0; n = 1;
        end
        for (int s = 0; s < n; s++) begin
            s_we[s]   = (who[s] == 1) && mw;
            s_addr[s] = (who[s] == 1) ? ma : ia;
            s_wd[s]   = md;
            idx       = s_addr[s][10:0];
            if (s_we[s]) ref_mem[idx] = md;
            else if (who[s] == 0) exp_if_rd = ref_mem[idx];
            else exp_mem_rd = ref_mem[idx];
            m_last      = who[s];
            snap_if[s]  = exp_if_rd;
            snap_mem[s] = exp_mem_rd;
        end
        if_req = ir; if_addr = ia; mem_r_en = mr; mem_w_en = mw; mem_addr = ma; mem_wdata = md;
        last_k = (n == 0) ? 2 : (n - 1) * (W + 2) + W + 2;
        for (int k = 1; k <= last_k; k++) begin
            @(negedge clk);
            e_cs = 0; e_we = 0; e_ir = 0; e_mr = 0; e_addr = '0; e_wd = '0;
            for (int s = 0; s < n; s++) begin
                g = s * (W + 2);
                if (k >= g + 1 && k <= g + W) begin
                    e_cs = 1; e_we = s_we[s]; e_addr = s_addr[s];
                    e_wd = s_we[s] ? s_wd[s] : '0;
                end
                if (k == g + W + 1) begin
                    if (who[s] == 0) e_ir = 1; else e_mr = 1;
                    check("rdata_at_ready", 64'({if_rdata, mem_rdata}), 64'({snap_if[s], snap_mem[s]}));
                end
            end
            check("sram_ctrl", 64'({sram_cs, sram_we, sram_addr}), 64'({e_cs, e_we, e_addr}));
            check("sram_wdata", 64'(sram_wdata), 64'(e_wd));
            check("ready", 64'({if_ready, mem_ready}), 64'({e_ir, e_mr}));
            check("stall", 64'({if_stall, mem_stall}), 64'({if_req & ~e_ir, (mem_r_en | mem_w_en) & ~e_mr}));
            if (obs_first < 0) begin
                if (mem_ready) obs_first = 1;
                else if (if_ready) obs_first = 0;
            end
            if (e_ir) if_req = 1'b0;
            if (e_mr) begin mem_r_en = 1'b0; mem_w_en = 1'b0; end
            if (scramble && k == 1 && n > 0) begin
                if (who[0] == 0) if_addr = $urandom;
                else begin mem_addr = $urandom; mem_wdata = $urandom; end
            end
        end
        n_txn++;
        $display("[TB] txn %0d: if_req=%0d mem_r=%0d mem_w=%0d first=%0d if_rdata=%h mem_rdata=%h",
                 n_txn, ir, mr, mw, obs_first, if_rdata, mem_rdata);
    endtask

    typedef struct {
        logic          ir;
        logic [BN-1:0] ia;
        logic          mr;
        logic          mw;
        logic [BN-1:0] ma;
        logic [BN-1:0] md;
        bit            scr;
        int            exp_first;
        logic [BN-1:0] exp_if;
        logic [BN-1:0] exp_mem;
    } vec_t;

    vec_t tbl [8];

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int obs;
        tbl[0] = '{1'b1, 32'h10,  1'b0, 1'b0, 32'h0,   32'h0,        1'b0, 0, 32'hE3A01005, 32'h0};
        tbl[1] = '{1'b0, 32'h0,   1'b0, 1'b1, 32'h400, 32'hDEADBEEF, 1'b0, 1, 32'hE3A01005, 32'h0};
        tbl[2] = '{1'b0, 32'h0,   1'b1, 1'b0, 32'h400, 32'h0,        1'b0, 1, 32'hE3A01005, 32'hDEADBEEF};
        tbl[3] = '{1'b1, 32'h20,  1'b1, 1'b0, 32'h10,  32'h0,        1'b0, TIE_RR_DEP, 32'hC0DE0020, 32'hE3A01005};
        tbl[4] = '{1'b1, 32'h400, 1'b1, 1'b0, 32'h20,  32'h0,        1'b0, TIE_RR_DEP, 32'hDEADBEEF, 32'hC0DE0020};
        tbl[5] = '{1'b0, 32'h0,   1'b1, 1'b1, 32'h30,  32'h12345678, 1'b1, 1, 32'hDEADBEEF, 32'hC0DE0020};
        tbl[6] = '{1'b1, 32'h30,  1'b0, 1'b0, 32'h0,   32'h0,        1'b0, 0, 32'h12345678, 32'hC0DE0020};
        tbl[7] = '{1'b1, 32'h40,  1'b0, 1'b1, 32'h40,  32'hA5A5A5A5, 1'b0, 1, 32'hA5A5A5A5, 32'hC0DE0020};

        for (int i = 0; i < MW; i++) begin
            sram_mem[i] = 32'hC0DE0000 | 32'(i);
            ref_mem[i]  = 32'hC0DE0000 | 32'(i);
        end
        sram_mem[16] = 32'hE3A01005;
        ref_mem[16]  = 32'hE3A01005;
        m_last = 0; exp_if_rd = '0; exp_mem_rd = '0;

        rst = 1'b1; if_req = 0; if_addr = '0; mem_r_en = 0; mem_w_en = 0; mem_addr = '0; mem_wdata = '0;
        repeat (3) @(negedge clk);
        check("reset_sram_ctrl", 64'({sram_cs, sram_we, sram_addr}), 64'(0));
        check("reset_sram_wdata", 64'(sram_wdata), 64'(0));
        check("reset_ready", 64'({if_ready, mem_ready}), 64'(0));
        check("reset_rdata", 64'({if_rdata, mem_rdata}), 64'(0));
        check("reset_stall", 64'({if_stall, mem_stall}), 64'(0));
        rst = 1'b0;
        @(negedge clk);

        for (int i = 0; i < 8; i++) begin
            do_txn(tbl[i].ir, tbl[i].ia, tbl[i].mr, tbl[i].mw, tbl[i].ma, tbl[i].md, tbl[i].scr, obs);
            check("tbl_first", 64'(obs), 64'(tbl[i].exp_first));
            check("tbl_if_rdata", 64'(if_rdata), 64'(tbl[i].exp_if));
            check("tbl_mem_rdata", 64'(mem_rdata), 64'(tbl[i].exp_mem));
        end

        // Reset during the second ACCESS cycle aborts the load with no ready pulse.
        mem_r_en = 1'b1; mem_addr = 32'h20;
        @(negedge clk);
        check("abort_cs1", 64'(sram_cs), 64'(1));
        @(negedge clk);
        check("abort_cs2", 64'(sram_cs), 64'(1));
        rst = 1'b1; mem_r_en = 1'b0;
        @(negedge clk);
        check("abort_after_rst", 64'({sram_cs, if_ready, mem_ready}), 64'(0));
        check("abort_rdata", 64'({if_rdata, mem_rdata}), 64'(0));
        rst = 1'b0;
        m_last = 0; exp_if_rd = '0; exp_mem_rd = '0;
        repeat (2) begin
            @(negedge clk);
            check("abort_quiet", 64'({sram_cs, if_ready, mem_ready}), 64'(0));
        end
        do_txn(1'b1, 32'h10, 1'b0, 1'b0, 32'h0, 32'h0, 1'b0, obs);
        check("abort_fresh_if", 64'(if_rdata), 64'(32'hE3A01005));

        // Random traffic against the reference model.
        for (int i = 0; i < 60; i++) begin
            logic ir, mr, mw;
            ir = 1'($urandom_range(0, 1));
            mr = 1'($urandom_range(0, 1));
            mw = 1'($urandom_range(0, 1));
            if (!ir && !mr && !mw) ir = 1'b1;
            do_txn(ir, 32'($urandom_range(0, 63)), mr, mw, 32'($urandom_range(0, 63)), $urandom,
                   1'($urandom_range(0, 1)), obs);
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule
